// File: rtl/pdm_frontend.sv
// pdm_frontend -- PDM microphone front end.
//
// Generates the microphone clock (micro_clk) from the system clock, selects
// which microphone of each L/R pair drives the shared data line (sel_lr),
// samples the PDM data lines at the end of each micro_clk phase and turns
// every sampled bit into a small signed word (+1 for 1, -1 for 0).
//
// Parameters
//   CLK_DIV    clk cycles per micro_clk period; even, >= 4 (>= 8 with the
//              input synchronizer enabled)
//   NUM_LINES  number of PDM data lines (one L/R mic pair per line)
//   OUT_W      signed sample width per line, >= 2
//
// Ports
//   clk           system clock, the only clock
//   rst           synchronous active-high reset, dominates everything
//   en_i          run enable for micro_clk generation and sampling
//   set_mode_i    mode write data: 00 left-only, 01 right-only, 10 stereo
//                 (11 is ignored)
//   set_mode_val  mode write strobe
//   micro_pdm_i   PDM data lines
//   micro_clk     microphone clock, registered, 50% duty
//   sel_lr        microphone select, 1 only in right-only mode
//   pdm_o         sample word, line k in pdm_o[k*OUT_W +: OUT_W]
//   pdm_vld       one-cycle strobe marking a new sample word
//   pdm_ch        channel tag of the word (0 = left, 1 = right)
//   dbg_state     current run state (0 = parked, 1 = running)
//
// Output protocol: pdm_vld is a one-cycle valid strobe with no ready/back-
// pressure; pdm_o and pdm_ch are valid in the pdm_vld cycle and hold their
// value until the next strobe.
//
// Build option: define PDM_INSYNC_EN to pass each data line through a
// 2-flop synchronizer before capture. Capture points stay the same, so the
// data seen at a capture point is the line value from 2 clk earlier.

module pdm_frontend #(
    parameter int CLK_DIV   = 4,
    parameter int NUM_LINES = 1,
    parameter int OUT_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [1:0]                 set_mode_i,
    input  logic                       set_mode_val,
    input  logic [NUM_LINES-1:0]       micro_pdm_i,
    output logic                       micro_clk,
    output logic                       sel_lr,
    output logic [NUM_LINES*OUT_W-1:0] pdm_o,
    output logic                       pdm_vld,
    output logic                       pdm_ch,
    output logic                       dbg_state
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int WORD_W = NUM_LINES * OUT_W;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(CLK_DIV / 2);

    localparam logic [1:0] MODE_LEFT    = 2'b00;
    localparam logic [1:0] MODE_RIGHT   = 2'b01;
    localparam logic [1:0] MODE_INVALID = 2'b11;

    typedef enum logic {
        ST_PARK = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    div_cnt_q,   div_cnt_d;
    logic                micro_clk_q, micro_clk_d;
    logic [1:0]          mode_act_q,  mode_act_d;
    logic [1:0]          mode_pend_q, mode_pend_d;
    logic [WORD_W-1:0]   pdm_o_q,     pdm_o_d;
    logic                pdm_vld_q,   pdm_vld_d;
    logic                pdm_ch_q,    pdm_ch_d;

    logic [NUM_LINES-1:0] pdm_bit;
    logic [WORD_W-1:0]    mapped;
    logic                 wrap;
    logic                 cap_left;
    logic                 cap_right;

    // ------------------------------------------------------------------
    // Optional input synchronizer
    // ------------------------------------------------------------------
`ifdef PDM_INSYNC_EN
    logic [NUM_LINES-1:0] sync1_q, sync1_d;
    logic [NUM_LINES-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = micro_pdm_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pdm_bit = sync2_q;
`else
    assign pdm_bit = micro_pdm_i;
`endif

    // ------------------------------------------------------------------
    // Bit-to-word mapping: 1 -> +1 (0..01), 0 -> -1 (1..11).
    // The LSB is always 1; the upper bits are the inverted data bit.
    // ------------------------------------------------------------------
    always_comb begin
        mapped = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            mapped[k*OUT_W +: OUT_W] = {{(OUT_W-1){~pdm_bit[k]}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        mode_pend_d = mode_pend_q;
        mode_act_d  = mode_act_q;
        pdm_o_d     = pdm_o_q;
        pdm_ch_d    = pdm_ch_q;
        pdm_vld_d   = 1'b0;

        wrap = (state_q == ST_RUN) && (div_cnt_q == CNT_LAST);

        // Captures use the mode active during the current period; a mode
        // taking effect at this wrap only governs the following period.
        cap_left  = (state_q == ST_RUN) && (div_cnt_q == CNT_HALF_LAST) &&
                    (mode_act_q != MODE_RIGHT);
        cap_right = (state_q == ST_RUN) && (div_cnt_q == CNT_LAST) &&
                    (mode_act_q != MODE_LEFT);

        // Period sequencing. A falling en_i is only acted on at the wrap,
        // so the current micro_clk period always completes.
        case (state_q)
            ST_PARK: begin
                if (en_i) begin
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    div_cnt_d = '0;
                    if (!en_i) begin
                        state_d = ST_PARK;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_PARK;
                div_cnt_d = '0;
            end
        endcase

        // micro_clk is high for the first half of the period; computed from
        // the next counter value so the flop lines up with div_cnt_q.
        micro_clk_d = (state_d == ST_RUN) && (div_cnt_d < CNT_HALF);

        // Mode writes land in the pending register; the active mode picks up
        // pending_d so a write coinciding with a wrap applies at that wrap.
        if (set_mode_val && (set_mode_i != MODE_INVALID)) begin
            mode_pend_d = set_mode_i;
        end
        if (wrap || !en_i) begin
            mode_act_d = mode_pend_d;
        end

        if (cap_left || cap_right) begin
            pdm_vld_d = 1'b1;
            pdm_ch_d  = cap_right;
            pdm_o_d   = mapped;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PARK;
            div_cnt_q   <= '0;
            micro_clk_q <= 1'b0;
            mode_act_q  <= MODE_LEFT;
            mode_pend_q <= MODE_LEFT;
            pdm_o_q     <= '0;
            pdm_vld_q   <= 1'b0;
            pdm_ch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            micro_clk_q <= micro_clk_d;
            mode_act_q  <= mode_act_d;
            mode_pend_q <= mode_pend_d;
            pdm_o_q     <= pdm_o_d;
            pdm_vld_q   <= pdm_vld_d;
            pdm_ch_q    <= pdm_ch_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign micro_clk = micro_clk_q;
    assign sel_lr    = (mode_act_q == MODE_RIGHT);
    assign pdm_o     = pdm_o_q;
    assign pdm_vld   = pdm_vld_q;
    assign pdm_ch    = pdm_ch_q;
    assign dbg_state = (state_q == ST_RUN);

endmodule
